// File: rtl/soma_comp_arb.sv
// soma_comp_arb: round-robin arbiter that lends one external two's-complement
// adder to two requesters. It latches the winner's operands, presents them to
// the adder for one cycle, registers the sum with a signed-overflow flag, and
// holds that result until the consumer acknowledges it.
module soma_comp_arb #(
    parameter int TAM = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [TAM-1:0] a0,
    input  logic [TAM-1:0] b0,
    input  logic           req1,
    input  logic [TAM-1:0] a1,
    input  logic [TAM-1:0] b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic [TAM-1:0] sum_a,
    output logic [TAM-1:0] sum_b,
    input  logic [TAM-1:0] sum_s,
    output logic [TAM-1:0] s,
    output logic           ovf,
    output logic           s_valid,
    output logic           s_owner,
    input  logic           ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic [TAM-1:0] op_a_q, op_a_d;
    logic [TAM-1:0] op_b_q, op_b_d;
    logic           owner_q, owner_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic [TAM-1:0] s_q, s_d;
    logic           ovf_q, ovf_d;
    logic           s_valid_q, s_valid_d;
    logic           s_owner_q, s_owner_d;
    logic           win;

    // Next-state logic: arbitration in IDLE, result capture in CALC, hold in DONE.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        s_d       = s_q;
        ovf_d     = ovf_q;
        s_valid_d = s_valid_q;
        s_owner_d = s_owner_q;
        // Requester 1 wins when it is alone, or when both ask and it holds priority.
        win       = req1 && (!req0 || prio_q);
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    op_a_d  = win ? a1 : a0;
                    op_b_d  = win ? b1 : b0;
                    owner_d = win;
                    gnt0_d  = !win;
                    gnt1_d  = win;
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d       = sum_s;
                // Overflow: like-signed operands producing a result of the other sign.
                ovf_d     = (op_a_q[TAM-1] == op_b_q[TAM-1]) &&
                            (sum_s[TAM-1] != op_a_q[TAM-1]);
                s_owner_d = owner_q;
                s_valid_d = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                if (ack) begin
                    s_valid_d = 1'b0;
                    prio_d    = ~owner_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            s_q       <= '0;
            ovf_q     <= 1'b0;
            s_valid_q <= 1'b0;
            s_owner_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            s_q       <= s_d;
            ovf_q     <= ovf_d;
            s_valid_q <= s_valid_d;
            s_owner_q <= s_owner_d;
        end
    end

    // The adder always sees the last latched operands.
    assign sum_a   = op_a_q;
    assign sum_b   = op_b_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign s       = s_q;
    assign ovf     = ovf_q;
    assign s_valid = s_valid_q;
    assign s_owner = s_owner_q;

endmodule

// File: tb/tb_soma_comp_arb.sv
// Self-checking bench for soma_comp_arb. The bench plays the external adder and
// keeps a transaction-level model: winner choice from a priority bit, the sum as
// modular arithmetic and overflow from signed integer range.
module tb_soma_comp_arb;
    localparam int TAM = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0, ack = 1'b0;
    logic [TAM-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           gnt0, gnt1, ovf, s_valid, s_owner;
    logic [TAM-1:0] sum_a, sum_b, sum_s, s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_prio = 0;

    soma_comp_arb #(.TAM(TAM)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .sum_a(sum_a), .sum_b(sum_b), .sum_s(sum_s),
        .s(s), .ovf(ovf), .s_valid(s_valid), .s_owner(s_owner),
        .ack(ack)
    );

    // External adder stand-in: modular sum, carry discarded.
    assign sum_s = sum_a + sum_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [TAM-1:0] exp_sum(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
        int t;
        t = (int'(a) + int'(b)) % (1 << TAM);
        return t[TAM-1:0];
    endfunction

    function automatic logic exp_ovf(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
        int sa, sb, t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = sa + sb;
        return (t > (1 << (TAM-1)) - 1) || (t < -(1 << (TAM-1)));
    endfunction

    // Stimulus driver: one request/grant/result/ack round trip, returning observations.
    task automatic txn(input logic r0, input logic r1, input bit keep, input int ack_wait,
                       output bit got, output int who, output int gnt_len, output bit both,
                       output int gcyc, output logic [TAM-1:0] sa_c, output logic [TAM-1:0] sb_c,
                       output logic sv, output logic [TAM-1:0] so, output logic ovo, output logic owo);
        got = 0; who = 0; gnt_len = 0; both = 0; gcyc = 0;
        sa_c = '0; sb_c = '0; sv = 0; so = '0; ovo = 0; owo = 0;
        req0 = r0;
        req1 = r1;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk); #1;
            if (gnt0 || gnt1) got = 1;
        end
        if (!got) begin
            req0 = 0;
            req1 = 0;
            return;
        end
        who  = gnt1 ? 1 : 0;
        both = gnt0 && gnt1;
        gcyc = cyc;
        sa_c = sum_a;
        sb_c = sum_b;
        if (!keep) begin
            req0 = 0;
            req1 = 0;
        end
        @(posedge clk); #1;
        gnt_len = (gnt0 || gnt1) ? 2 : 1;
        sv  = s_valid;
        so  = s;
        ovo = ovf;
        owo = s_owner;
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk); #1;
        end
        ack = 1;
        @(posedge clk); #1;
        ack = 0;
        $display("TXN req=%b%b winner=%0d s=%b ovf=%b owner=%b cyc=%0d", r1, r0, who, so, ovo, owo, gcyc);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        model_prio = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({gnt0, gnt1, s_valid, s_owner, ovf} !== 5'b0 || s !== '0 || sum_a !== '0 || sum_b !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b%b sv=%b own=%b ovf=%b s=%b sa=%b sb=%b need all zero",
                     gnt1, gnt0, s_valid, s_owner, ovf, s, sum_a, sum_b);
        end
        rst = 0;
        model_prio = 0;
        @(posedge clk); #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got gnt=%b%b sv=%b need 000", gnt1, gnt0, s_valid);
        end
    endtask

    // Single requester transactions: directed table then random operands.
    task automatic test_single();
        logic [TAM-1:0] ta[4] = '{4'b1010, 4'b0001, 4'b0111, 4'b1000};
        logic [TAM-1:0] tb[4] = '{4'b0101, 4'b0011, 4'b0001, 4'b1000};
        bit             tr[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit got, both; int who, glen, gcyc;
        logic [TAM-1:0] sa_c, sb_c, so, ea, eb; logic sv, ovo, owo;
        logic r;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin
                r = tr[k]; ea = ta[k]; eb = tb[k];
            end else begin
                r = 1'($urandom_range(0, 1)); ea = TAM'($urandom); eb = TAM'($urandom);
            end
            a0 = r ? TAM'($urandom) : ea; b0 = r ? TAM'($urandom) : eb;
            a1 = r ? ea : TAM'($urandom); b1 = r ? eb : TAM'($urandom);
            txn(!r, r, 0, 0, got, who, glen, both, gcyc, sa_c, sb_c, sv, so, ovo, owo);
            checks++;
            if (!got || who != int'(r) || both) begin
                errors++;
                $display("FAIL single_grant k=%0d got=%0d who=%0d both=%0d need who=%0d", k, got, who, both, r);
            end
            checks++;
            if (glen != 1 || sa_c !== ea || sb_c !== eb) begin
                errors++;
                $display("FAIL single_calc k=%0d glen=%0d sum_a=%b sum_b=%b need 1 %b %b", k, glen, sa_c, sb_c, ea, eb);
            end
            checks++;
            if (sv !== 1'b1 || so !== exp_sum(ea, eb) || ovo !== exp_ovf(ea, eb) || owo !== r) begin
                errors++;
                $display("FAIL single_result k=%0d sv=%b s=%b ovf=%b own=%b need 1 %b %b %b",
                         k, sv, so, ovo, owo, exp_sum(ea, eb), exp_ovf(ea, eb), r);
            end
            checks++;
            if (s_valid !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL single_after_ack k=%0d sv=%b gnt=%b%b need 000", k, s_valid, gnt1, gnt0);
            end
            model_prio = r ? 0 : 1;
        end
    endtask

    // Both requests held continuously from reset: strict alternation every 3 cycles.
    task automatic test_fairness();
        bit got, both; int who, glen, gcyc, prev, ew;
        logic [TAM-1:0] sa_c, sb_c, so; logic sv, ovo, owo;
        do_reset();
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            a0 = TAM'($urandom); b0 = TAM'($urandom);
            a1 = TAM'($urandom); b1 = TAM'($urandom);
            ew = model_prio;
            txn(1, 1, 1, 0, got, who, glen, both, gcyc, sa_c, sb_c, sv, so, ovo, owo);
            checks++;
            if (!got || who != ew || both || owo !== ew[0]) begin
                errors++;
                $display("FAIL fair_order k=%0d got=%0d who=%0d both=%0d own=%b need %0d", k, got, who, both, owo, ew);
            end
            checks++;
            if (so !== (ew == 1 ? exp_sum(a1, b1) : exp_sum(a0, b0)) ||
                ovo !== (ew == 1 ? exp_ovf(a1, b1) : exp_ovf(a0, b0))) begin
                errors++;
                $display("FAIL fair_result k=%0d s=%b ovf=%b", k, so, ovo);
            end
            if (k > 0) begin
                checks++;
                if (gcyc - prev != 3) begin
                    errors++;
                    $display("FAIL fair_interval k=%0d got=%0d need 3", k, gcyc - prev);
                end
            end
            prev = gcyc;
            model_prio = (ew == 0) ? 1 : 0;
        end
        req0 = 0;
        req1 = 0;
        @(posedge clk); #1;
    endtask

    // Result must hold through a long ack stall while inputs wander.
    task automatic test_hold();
        logic [TAM-1:0] ea, eb, es; logic eo; bit got;
        ea = TAM'($urandom); eb = TAM'($urandom);
        a0 = ea; b0 = eb; req0 = 1; got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk); #1;
            if (gnt0) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL hold_grant timeout gnt0=%b need 1", gnt0);
        end
        req0 = 0;
        @(posedge clk); #1;
        es = exp_sum(ea, eb);
        eo = exp_ovf(ea, eb);
        for (int i = 0; i < 10; i++) begin
            a0 = TAM'($urandom); b0 = TAM'($urandom); a1 = TAM'($urandom); b1 = TAM'($urandom);
            req1 = 1;
            checks++;
            if (s_valid !== 1'b1 || s !== es || ovf !== eo || s_owner !== 1'b0 || gnt1 !== 1'b0 || sum_a !== ea) begin
                errors++;
                $display("FAIL hold_stable i=%0d sv=%b s=%b ovf=%b own=%b gnt1=%b sum_a=%b need 1 %b %b 0 0 %b",
                         i, s_valid, s, ovf, s_owner, gnt1, sum_a, es, eo, ea);
            end
            @(posedge clk); #1;
        end
        ack = 1;
        @(posedge clk); #1;
        ack = 0;
        req1 = 0;
        model_prio = 1;
        $display("TXN hold winner=0 s=%b ovf=%b", es, eo);
        @(posedge clk); #1;
    endtask

    // Reset in CALC and in DONE clears outputs at once and restores priority to requester 0.
    task automatic test_reset_abort();
        bit got;
        for (int phase = 0; phase < 2; phase++) begin
            a1 = TAM'($urandom) | 1; b1 = TAM'($urandom); req1 = 1; got = 0;
            for (int i = 0; i < 12 && !got; i++) begin
                @(posedge clk); #1;
                if (gnt1) got = 1;
            end
            req1 = 0;
            if (phase == 1) begin
                @(posedge clk); #1;
            end
            checks++;
            if (!got || (phase == 1 && s_valid !== 1'b1)) begin
                errors++;
                $display("FAIL abort_setup phase=%0d got=%0d sv=%b", phase, got, s_valid);
            end
            #2 rst = 1;
            #1;
            checks++;
            if ({gnt0, gnt1, s_valid, s_owner, ovf} !== 5'b0 || s !== '0 || sum_a !== '0 || sum_b !== '0) begin
                errors++;
                $display("FAIL abort_clear phase=%0d gnt=%b%b sv=%b own=%b ovf=%b s=%b sa=%b need zeros",
                         phase, gnt1, gnt0, s_valid, s_owner, ovf, s, sum_a);
            end
            @(posedge clk); #1;
            rst = 0;
            model_prio = 0;
            a0 = TAM'($urandom); b0 = TAM'($urandom);
            req0 = 1; req1 = 1; got = 0;
            for (int i = 0; i < 12 && !got; i++) begin
                @(posedge clk); #1;
                if (gnt0 || gnt1) got = 1;
            end
            checks++;
            if (!got || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL abort_first phase=%0d gnt=%b%b need 01", phase, gnt1, gnt0);
            end
            req0 = 0; req1 = 0;
            @(posedge clk); #1;
            ack = 1;
            @(posedge clk); #1;
            ack = 0;
            model_prio = 1;
            $display("TXN abort phase=%0d then winner=0", phase);
        end
    endtask

    // Random mix of requests and ack stalls against the priority model.
    task automatic test_random();
        bit got, both; int who, glen, gcyc, ew, rr;
        logic [TAM-1:0] sa_c, sb_c, so, ea, eb; logic sv, ovo, owo;
        for (int k = 0; k < 20; k++) begin
            rr = $urandom_range(1, 3);
            a0 = TAM'($urandom); b0 = TAM'($urandom); a1 = TAM'($urandom); b1 = TAM'($urandom);
            ew = (rr == 3) ? model_prio : (rr == 2 ? 1 : 0);
            ea = (ew == 1) ? a1 : a0;
            eb = (ew == 1) ? b1 : b0;
            txn(rr[0], rr[1], 0, $urandom_range(0, 3), got, who, glen, both, gcyc, sa_c, sb_c, sv, so, ovo, owo);
            checks++;
            if (!got || who != ew || both || glen != 1) begin
                errors++;
                $display("FAIL rand_grant k=%0d got=%0d who=%0d both=%0d glen=%0d need %0d", k, got, who, both, glen, ew);
            end
            checks++;
            if (sv !== 1'b1 || so !== exp_sum(ea, eb) || ovo !== exp_ovf(ea, eb) || owo !== ew[0]) begin
                errors++;
                $display("FAIL rand_result k=%0d sv=%b s=%b ovf=%b own=%b need 1 %b %b %0d",
                         k, sv, so, ovo, owo, exp_sum(ea, eb), exp_ovf(ea, eb), ew);
            end
            model_prio = (ew == 0) ? 1 : 0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_hold();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
